spi_slave_if: RTL and testbench



---
 rtl/spi_slave_if.sv | 116 +++++++++++
 tb/tb_spi_slave_if.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit command/address/data words from MOSI for the RAM and returns read bytes on MISO.
// Latency: rx_valid one cycle after the 10th data bit; MISO carries bit 7 one cycle after tx_valid.
// No backpressure: the master owns the pace; a high SS_n aborts the frame at once and any partial word is dropped.
module spi_slave_if #(
    parameter int WORD_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int TXC_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] WORD_DONE = CNT_W'(WORD_W);
    localparam logic [TXC_W-1:0] TX_DONE   = TXC_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-2:0] rx_shift;
    logic [DATA_W-2:0] tx_shift;
    logic [TXC_W-1:0]  tx_cnt;
    logic              rd_addr_seen;
    logic              in_rx;

    assign in_rx = !SS_n && (state == WRITE || state == READ_ADD || state == READ_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!SS_n) state_nxt = CHK_CMD;
            end
            CHK_CMD: begin
                // The decision bit only steers the FSM; it never enters the word.
                if (SS_n)              state_nxt = IDLE;
                else if (!MOSI)        state_nxt = WRITE;
                else if (rd_addr_seen) state_nxt = READ_DATA;
                else                   state_nxt = READ_ADD;
            end
            default: begin
                if (SS_n) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            MISO         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (!in_rx) begin
                // Idle, decision cycle or abort: start the next frame from scratch.
                bit_cnt <= '0;
                tx_cnt  <= '0;
                MISO    <= 1'b0;
            end else if (bit_cnt != WORD_DONE) begin
                rx_shift <= {rx_shift[WORD_W-3:0], MOSI};
                bit_cnt  <= bit_cnt + CNT_W'(1);
                if (bit_cnt == LAST_BIT) begin
                    rx_data  <= {rx_shift, MOSI};
                    rx_valid <= 1'b1;
                    if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                    if (state == READ_DATA) rd_addr_seen <= 1'b0;
                end
            end else if (state == READ_DATA) begin
                // Word received; bits past the 10th are ignored and only the read byte moves.
                if (tx_cnt == '0) begin
                    if (tx_valid) begin
                        MISO     <= tx_data[DATA_W-1];
                        tx_shift <= tx_data[DATA_W-2:0];
                        tx_cnt   <= TXC_W'(1);
                    end
                end else if (tx_cnt != TX_DONE) begin
                    MISO     <= tx_shift[DATA_W-2];
                    tx_shift <= {tx_shift[DATA_W-3:0], 1'b0};
                    tx_cnt   <= tx_cnt + TXC_W'(1);
                end else begin
                    MISO <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a monitor checks every rx_valid word against a queue of expected words.
module tb_spi_slave_if;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];

    spi_slave_if #(.WORD_W(10), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start(input logic dec);
        SS_n = 1'b0;
        MOSI = 1'b0;
        tick();
        MOSI = dec;
        tick();
    endtask

    // Sends n bits of w MSB first; bits past the 10th are random filler.
    task automatic send_bits(input logic [9:0] w, input int n, input logic chk0, input string name);
        for (int i = 0; i < n; i++) begin
            if (i < 10) MOSI = w[9-i];
            else        MOSI = 1'($urandom_range(0, 1));
            tick();
            if (chk0) check(name, 32'(MISO), 32'd0);
        end
    endtask

    task automatic send_word(input logic dec, input logic [9:0] w);
        exp_q.push_back(w);
        frame_start(dec);
        send_bits(w, 10, 1'b0, "");
    endtask

    task automatic frame_end();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    task automatic miso_quiet(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            tick();
            tx_valid = 1'b0;
            check(name, 32'(MISO), 32'd0);
        end
    endtask

    // Monitor: every rx_valid must match the oldest expected word and last a single cycle.
    initial begin
        logic       prev_vld;
        logic [9:0] e;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_vld = 1'b0;
            end else begin
                if (rx_valid && prev_vld) check("rx_valid_width", 32'd2, 32'd1);
                if (rx_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rx_valid", 32'(rx_data), 32'h3ff);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_word", 32'(rx_data), 32'(e));
                    end
                end
                prev_vld = rx_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_b;
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) tick();
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Stray tx_valid in IDLE.
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        miso_quiet(2, "idle_tx_valid_miso");

        // Write 0x0A5 with tx_valid held high through the frame.
        exp_q.push_back(10'h0A5);
        tx_valid = 1'b1;
        frame_start(1'b0);
        send_bits(10'h0A5, 10, 1'b1, "write_miso");
        tx_valid = 1'b0;
        frame_end();

        // Write 0x13C followed by extra bits: one word only.
        exp_q.push_back(10'h13C);
        frame_start(1'b0);
        send_bits(10'h13C, 13, 1'b1, "write_extra_miso");
        tx_valid = 1'b1;
        miso_quiet(3, "write_tx_valid_miso");
        check("rx_data_hold", 32'(rx_data), 32'h13C);
        frame_end();

        // First read frame lands in READ_ADD: tx_valid has no effect.
        send_word(1'b1, 10'h207);
        tick();
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        miso_quiet(9, "read_add_miso");
        frame_end();

        // Second read frame lands in READ_DATA and returns 0xC3.
        send_word(1'b1, 10'h300);
        tick();
        exp_b    = 8'hC3;
        tx_data  = exp_b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("tx_bit7", 32'(MISO), 32'(exp_b[7]));
        for (int k = 6; k >= 0; k--) begin
            if (k == 4) begin
                tx_valid = 1'b1;
                tx_data  = 8'h00;
            end
            tick();
            tx_valid = 1'b0;
            check("tx_bit", 32'(MISO), 32'(exp_b[k]));
        end
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        miso_quiet(3, "tx_after_byte_miso");
        frame_end();

        // rd_addr_seen was cleared: next read is an address phase again.
        send_word(1'b1, 10'h2F0);
        tick();
        tx_valid = 1'b1;
        miso_quiet(9, "read_add_again_miso");
        frame_end();

        // Abort after 6 bits, then a clean write.
        frame_start(1'b0);
        send_bits(10'h155, 6, 1'b0, "");
        frame_end();
        tick();
        send_word(1'b0, 10'h155);
        frame_end();

        // SS_n rises on the 10th-bit edge: abort wins.
        frame_start(1'b0);
        send_bits(10'h0F0, 9, 1'b0, "");
        MOSI = 1'b0;
        SS_n = 1'b1;
        tick();
        tick();
        check("rx_data_after_abort", 32'(rx_data), 32'h155);

        // Aborted write left rd_addr_seen set: READ_DATA, then reset mid-transmit.
        send_word(1'b1, 10'h381);
        tick();
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        check("pre_reset_miso", 32'(MISO), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_miso", 32'(MISO), 32'd0);
        check("arst_rx_valid", 32'(rx_valid), 32'd0);
        check("arst_rx_data", 32'(rx_data), 32'd0);
        SS_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        send_word(1'b1, 10'h2AB);
        tick();
        tx_valid = 1'b1;
        miso_quiet(9, "post_reset_read_add_miso");

        // Reset with rd_addr_seen set also clears it.
        rst_n = 1'b0;
        tick();
        SS_n  = 1'b1;
        rst_n = 1'b1;
        tick();
        send_word(1'b1, 10'h211);
        tick();
        tx_valid = 1'b1;
        miso_quiet(9, "reset_clears_seen_miso");
        frame_end();

        repeat (4) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
